// File: rtl/entropy_src_pkg.sv
// Shared types and default widths for the entropy source health-test alert aggregator.
package entropy_src_pkg;

    localparam int unsigned HtNumTests   = 4;
    localparam int unsigned HtRegWidth   = 16;
    localparam int unsigned HtAlertWidth = 4;

    // Sparse encoding: any single bit flip lands on an illegal state that decodes back to IDLE.
    typedef enum logic [5:0] {
        HtAggIdle    = 6'b011001,
        HtAggRun     = 6'b100111,
        HtAggAlerted = 6'b111100
    } ht_agg_state_e;

endpackage

// File: rtl/entropy_src_ht_sat_cntr.sv
// Saturating up-counter with synchronous clear, backed by a complemented shadow copy
// whose disagreement with the primary register is flagged on err_o.
module entropy_src_ht_sat_cntr #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             incr_i,
    output logic [Width-1:0] cnt_o,
    output logic             err_o
);

    logic [Width-1:0] cnt_q, cnt_inv_q, cnt_d;

    // NOTE: the default assignment first means every path writes cnt_d, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (incr_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            cnt_inv_q <= '1;
        end else begin
            cnt_q     <= cnt_d;
            cnt_inv_q <= ~cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = (cnt_q != ~cnt_inv_q);

endmodule

// File: rtl/entropy_src_ht_alert_agg.sv
// Health-test alert aggregator: per-test fail totals, consecutive failing-window alert,
// and an optional count high-watermark built only when ENTROPY_SRC_HT_WATERMARK_EN is defined.
module entropy_src_ht_alert_agg
    import entropy_src_pkg::*;
#(
    parameter int unsigned NumTests   = HtNumTests,
    parameter int unsigned RegWidth   = HtRegWidth,
    parameter int unsigned AlertWidth = HtAlertWidth
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         active_i,
    input  logic                         clear_i,
    input  logic [NumTests-1:0]          test_fail_pulse_i,
    input  logic [NumTests*RegWidth-1:0] test_cnt_i,
    input  logic                         window_wrap_pulse_i,
    input  logic [AlertWidth-1:0]        alert_thresh_i,
    output logic                         alert_o,
    output logic [AlertWidth-1:0]        alert_cnt_o,
    output logic [NumTests*RegWidth-1:0] fail_totals_o,
    output logic [RegWidth-1:0]          hi_watermark_o,
    output logic                         count_err_o
);

    ht_agg_state_e         state_q, state_d;
    logic                  alert_q, win_fail_q, count_err_q;
    logic                  ht_en, fail_any, wrap_en, close_fail, alert_hit;
    logic [AlertWidth-1:0] alert_cnt, alert_cnt_inc;
    logic [NumTests:0]     cnt_err;

    // Counting happens only once the FSM has left IDLE and nothing higher-priority is pending.
    assign ht_en         = (state_q != HtAggIdle) && active_i && !clear_i;
    assign fail_any      = |test_fail_pulse_i;
    assign wrap_en       = ht_en && window_wrap_pulse_i;
    assign close_fail    = win_fail_q || fail_any;
    assign alert_cnt_inc = (alert_cnt == '1) ? alert_cnt : alert_cnt + AlertWidth'(1);
    assign alert_hit     = wrap_en && close_fail && (alert_thresh_i != '0) &&
                           (alert_cnt_inc >= alert_thresh_i);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HtAggIdle:    if (active_i && !clear_i) state_d = HtAggRun;
            HtAggRun: begin
                if (clear_i || !active_i) state_d = HtAggIdle;
                else if (alert_hit)       state_d = HtAggAlerted;
            end
            HtAggAlerted: if (clear_i || !active_i) state_d = HtAggIdle;
            default:      state_d = HtAggIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HtAggIdle;
            alert_q     <= 1'b0;
            win_fail_q  <= 1'b0;
            count_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alert_q     <= (state_d == HtAggAlerted);
            count_err_q <= !clear_i && (|cnt_err);
            if (clear_i || !active_i || wrap_en) begin
                win_fail_q <= 1'b0;
            end else if (ht_en && fail_any) begin
                win_fail_q <= 1'b1;
            end
        end
    end

    entropy_src_ht_sat_cntr #(.Width(AlertWidth)) u_alert_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clear_i || !active_i || (wrap_en && !close_fail)),
        .incr_i (wrap_en && close_fail),
        .cnt_o  (alert_cnt),
        .err_o  (cnt_err[NumTests])
    );

    for (genvar k = 0; k < NumTests; k++) begin : g_total
        entropy_src_ht_sat_cntr #(.Width(RegWidth)) u_total (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clear_i),
            .incr_i (ht_en && test_fail_pulse_i[k]),
            .cnt_o  (fail_totals_o[k*RegWidth +: RegWidth]),
            .err_o  (cnt_err[k])
        );
    end

`ifdef ENTROPY_SRC_HT_WATERMARK_EN
    logic [RegWidth-1:0] wm_q, wm_max;

    always_comb begin
        wm_max = wm_q;
        for (int k = 0; k < NumTests; k++) begin
            if (test_cnt_i[k*RegWidth +: RegWidth] > wm_max) wm_max = test_cnt_i[k*RegWidth +: RegWidth];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     wm_q <= '0;
        else if (clear_i) wm_q <= '0;
        else if (ht_en)   wm_q <= wm_max;
    end

    assign hi_watermark_o = wm_q;
`else
    logic unused_test_cnt;
    assign unused_test_cnt = ^test_cnt_i;
    assign hi_watermark_o  = '0;
`endif

    assign alert_o     = alert_q;
    assign alert_cnt_o = alert_cnt;
    assign count_err_o = count_err_q;

endmodule
